// File: rtl/lsq_cdb_buffer_if.sv
// lsq_cdb_buffer_if
//   Groups the LSQ writeback input, the CDB request/grant handshake, the
//   flush strobe and the status outputs of the LSQ-to-CDB staging buffer.
//   Modports:
//     slave  - the buffer itself (receives writebacks, grant, flush; drives
//              the CDB head entry and status)
//     master - the environment (LSQ, CDB arbiter, snapshot-restore logic)
//   Signals:
//     lsq_wb_valid_i / _rob_idx_i / _data_i / _prf_i : load writeback
//     flush_i        : snapshot restore, drops every buffered entry
//     cdb_req_o      : head entry valid
//     cdb_grant_i    : same-cycle grant from the CDB arbiter
//     cdb_rob_idx_o / cdb_data_o / cdb_prf_o : head entry fields
//     buf_full_o, count_o, overflow_o        : status
interface lsq_cdb_buffer_if #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned PRF_IDX_W = 6
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                 lsq_wb_valid_i;
  logic [ROB_IDX_W-1:0] lsq_wb_rob_idx_i;
  logic [31:0]          lsq_wb_data_i;
  logic [PRF_IDX_W-1:0] lsq_wb_prf_i;
  logic                 flush_i;
  logic                 cdb_req_o;
  logic                 cdb_grant_i;
  logic [ROB_IDX_W-1:0] cdb_rob_idx_o;
  logic [31:0]          cdb_data_o;
  logic [PRF_IDX_W-1:0] cdb_prf_o;
  logic                 buf_full_o;
  logic [CNT_W-1:0]     count_o;
  logic                 overflow_o;

  modport slave (
    input  lsq_wb_valid_i, lsq_wb_rob_idx_i, lsq_wb_data_i, lsq_wb_prf_i,
    input  flush_i, cdb_grant_i,
    output cdb_req_o, cdb_rob_idx_o, cdb_data_o, cdb_prf_o,
    output buf_full_o, count_o, overflow_o
  );

  modport master (
    output lsq_wb_valid_i, lsq_wb_rob_idx_i, lsq_wb_data_i, lsq_wb_prf_i,
    output flush_i, cdb_grant_i,
    input  cdb_req_o, cdb_rob_idx_o, cdb_data_o, cdb_prf_o,
    input  buf_full_o, count_o, overflow_o
  );
endinterface

// File: rtl/lsq_cdb_buffer.sv
// lsq_cdb_buffer
//   Circular FIFO staging completed load results between the LSQ and the CDB.
//   Every LSQ writeback is captured; the oldest entry is offered to the CDB
//   arbiter and popped when granted. A flush discards all entries. A writeback
//   arriving while full with no same-cycle pop is dropped and latches the
//   sticky overflow flag (cleared only by reset).
//   Ports:
//     clock - system clock, all state on posedge
//     reset - synchronous active-high, clears pointers, count and overflow
//     bus   - lsq_cdb_buffer_if.slave (writeback in, CDB handshake, status)
module lsq_cdb_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned PRF_IDX_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  lsq_cdb_buffer_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ROB_IDX_W-1:0] rob_mem  [DEPTH];
  logic [31:0]          data_mem [DEPTH];
  logic [PRF_IDX_W-1:0] prf_mem  [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic req;
  logic full;
  logic deq;
  logic enq;
  logic drop;

  assign req  = (count != '0);
  assign full = (count == CNT_W'(DEPTH));

  // Flush masks both enq and deq so the same-cycle writeback/grant are ignored.
  // A full buffer still accepts a writeback when the head is popped this cycle.
  always_comb begin
    deq  = 1'b0;
    enq  = 1'b0;
    drop = 1'b0;
    if (!bus.flush_i) begin
      deq  = req && bus.cdb_grant_i;
      enq  = bus.lsq_wb_valid_i && (!full || deq);
      drop = bus.lsq_wb_valid_i && !enq;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bus.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(deq);
      if (drop) overflow <= 1'b1;
    end
  end

  // Entry storage needs no reset: contents are only visible while count != 0.
  always_ff @(posedge clock) begin
    if (enq && !reset) begin
      rob_mem[tail]  <= bus.lsq_wb_rob_idx_i;
      data_mem[tail] <= bus.lsq_wb_data_i;
      prf_mem[tail]  <= bus.lsq_wb_prf_i;
    end
  end

  assign bus.cdb_req_o     = req;
  assign bus.cdb_rob_idx_o = req ? rob_mem[head]  : '0;
  assign bus.cdb_data_o    = req ? data_mem[head] : '0;
  assign bus.cdb_prf_o     = req ? prf_mem[head]  : '0;
  assign bus.buf_full_o    = full;
  assign bus.count_o       = count;
  assign bus.overflow_o    = overflow;
endmodule
